// File: rtl/somador_serial_param.sv
// Digit-serial adder/subtractor: adds/subtracts two N-bit operands D bits
// per clock with a registered carry. Start/pronto/done handshake. The last
// result is held on S/C_out/overflow until the next operation completes.
module somador_serial_param #(
  parameter int N = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         C_in,
  output logic         pronto,
  output logic         done,
  output logic [N-1:0] S,
  output logic         C_out,
  output logic         overflow
);

  localparam int            ND   = N / D;
  localparam int            CW   = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [CW-1:0] LAST = CW'(ND - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIM} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  // a_sh doubles as the result register: operand digits leave at the LSB
  // end while sum digits enter at the MSB end, so after ND steps it holds S.
  logic [N-1:0]  a_sh;
  logic [N-1:0]  b_sh;
  logic          carry;
  logic          a_msb;
  logic          b_msb;

  logic [N-1:0]  b_prime;
  logic [D:0]    dig;
  logic [N-1:0]  a_next;
  logic [N-1:0]  b_next;

  // operand B inverted for subtraction (A + ~B + ~borrow)
  assign b_prime = sub ? ~B : B;

  // one digit of the ripple: low D bits of both shifters plus the carry
  always_comb begin
    dig = {1'b0, a_sh[D-1:0]} + {1'b0, b_sh[D-1:0]} + {{D{1'b0}}, carry};
  end

  generate
    if (D == N) begin : g_single
      assign a_next = dig[D-1:0];
      assign b_next = '0;
    end else begin : g_multi
      assign a_next = {dig[D-1:0], a_sh[N-1:D]};
      assign b_next = {{D{1'b0}}, b_sh[N-1:D]};
    end
  endgenerate

  // control FSM, datapath shifters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      carry    <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      S        <= '0;
      C_out    <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
      pronto   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= A;
            b_sh   <= b_prime;
            carry  <= sub ^ C_in;
            a_msb  <= A[N-1];
            b_msb  <= b_prime[N-1];
            cnt    <= '0;
            pronto <= 1'b0;
            state  <= CALC;
          end
        end
        CALC: begin
          a_sh  <= a_next;
          b_sh  <= b_next;
          carry <= dig[D];
          if (cnt == LAST) begin
            S        <= a_next;
            C_out    <= dig[D];
            overflow <= (a_msb == b_msb) && (a_next[N-1] != a_msb);
            done     <= 1'b1;
            state    <= FIM;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FIM: begin
          done   <= 1'b0;
          pronto <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          done   <= 1'b0;
          pronto <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_somador_serial_param.sv
// Bench for somador_serial_param: three instances (8/2, 4/1, 4/4) checked
// every cycle against a cycle-count/arithmetic model, plus directed cases.
module tb_somador_serial_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start_v = '0;
  logic [2:0] sub_v = '0;
  logic [2:0] ci_v = '0;
  logic [7:0] a_v [3];
  logic [7:0] b_v [3];

  logic [7:0] s0;
  logic [3:0] s1, s2;
  logic       p0, p1, p2, d0, d1, d2, c0, c1, c2, v0, v1, v2;

  logic [7:0] s_o [3];
  logic [2:0] p_o, d_o, c_o, v_o;

  int n_tot = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  somador_serial_param #(.N(8), .D(2)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub_v[0]), .A(a_v[0]), .B(b_v[0]),
    .C_in(ci_v[0]), .pronto(p0), .done(d0), .S(s0), .C_out(c0), .overflow(v0));
  somador_serial_param #(.N(4), .D(1)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub_v[1]), .A(a_v[1][3:0]), .B(b_v[1][3:0]),
    .C_in(ci_v[1]), .pronto(p1), .done(d1), .S(s1), .C_out(c1), .overflow(v1));
  somador_serial_param #(.N(4), .D(4)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub_v[2]), .A(a_v[2][3:0]), .B(b_v[2][3:0]),
    .C_in(ci_v[2]), .pronto(p2), .done(d2), .S(s2), .C_out(c2), .overflow(v2));

  always_comb begin
    s_o[0] = s0;
    s_o[1] = {4'h0, s1};
    s_o[2] = {4'h0, s2};
    p_o = {p2, p1, p0};
    d_o = {d2, d1, d0};
    c_o = {c2, c1, c0};
    v_o = {v2, v1, v0};
  end

  function automatic int nw(input int k);
    return (k == 0) ? 8 : 4;
  endfunction

  function automatic int lat(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  // {overflow, carry_out, sum} from plain integer arithmetic
  function automatic logic [9:0] calc(input int n, input logic [7:0] a, input logic [7:0] b,
                                      input logic ci, input logic sb);
    int mask, half, ai, bi, c0i, tot, sa, sbs, st;
    logic [9:0] r;
    mask = (1 << n) - 1;
    half = 1 << (n - 1);
    ai   = int'(a) & mask;
    bi   = sb ? (~int'(b)) & mask : int'(b) & mask;
    c0i  = (sb ? !ci : ci) ? 1 : 0;
    tot  = ai + bi + c0i;
    sa   = (ai >= half) ? ai - 2 * half : ai;
    sbs  = (bi >= half) ? bi - 2 * half : bi;
    st   = sa + sbs + c0i;
    r[7:0] = 8'(tot & mask);
    r[8]   = ((tot >> n) & 1) != 0;
    r[9]   = (st < -half) || (st > half - 1);
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // model: an accepted op completes lat edges later; busy one more edge
  int         cyc;
  logic       busy [3];
  int         acc [3];
  logic [9:0] pend [3];
  logic [7:0] m_s [3];
  logic       m_c [3], m_v [3], m_d [3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc <= 0;
      for (int k = 0; k < 3; k++) begin
        busy[k] <= 1'b0; acc[k] <= 0; pend[k] <= '0;
        m_s[k] <= '0; m_c[k] <= 1'b0; m_v[k] <= 1'b0; m_d[k] <= 1'b0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int k = 0; k < 3; k++) begin
        m_d[k] <= 1'b0;
        if (busy[k] && cyc == acc[k] + lat(k)) begin
          m_s[k] <= pend[k][7:0];
          m_c[k] <= pend[k][8];
          m_v[k] <= pend[k][9];
          m_d[k] <= 1'b1;
        end
        if (busy[k] && cyc == acc[k] + lat(k) + 1) busy[k] <= 1'b0;
        if (!busy[k] && start_v[k]) begin
          busy[k] <= 1'b1;
          acc[k]  <= cyc;
          pend[k] <= calc(nw(k), a_v[k], b_v[k], ci_v[k], sub_v[k]);
        end
      end
    end
  end

  // per-cycle comparison of every instance against the model
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("S[%0d]", k), int'(s_o[k]), int'(m_s[k]));
      chk($sformatf("C_out[%0d]", k), int'(c_o[k]), int'(m_c[k]));
      chk($sformatf("overflow[%0d]", k), int'(v_o[k]), int'(m_v[k]));
      chk($sformatf("done[%0d]", k), int'(d_o[k]), int'(m_d[k]));
      chk($sformatf("pronto[%0d]", k), int'(p_o[k]), int'(!busy[k]));
    end
  end

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    @(negedge clk);
    while (!p_o[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!p_o[k]) chk($sformatf("timeout_idle[%0d]", k), 0, 1);
  endtask

  task automatic op0(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sb);
    wait_idle(0);
    a_v[0] = a; b_v[0] = b; ci_v[0] = ci; sub_v[0] = sb;
    start_v[0] = 1'b1;
    @(posedge clk); #2;
    start_v[0] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lowc, ndone;
    for (int k = 0; k < 3; k++) begin a_v[k] = '0; b_v[k] = '0; end

    // pin the model with hand-computed values
    chk("model_add", int'(calc(8, 8'h5A, 8'h3C, 1'b0, 1'b0)), int'({1'b1, 1'b0, 8'h96}));
    chk("model_carry", int'(calc(8, 8'hFF, 8'h01, 1'b1, 1'b0)), int'({1'b0, 1'b1, 8'h01}));
    chk("model_sub", int'(calc(8, 8'h10, 8'h20, 1'b0, 1'b1)), int'({1'b0, 1'b0, 8'hF0}));
    chk("model_subov", int'(calc(8, 8'h80, 8'h01, 1'b0, 1'b1)), int'({1'b1, 1'b1, 8'h7F}));
    chk("model_n4", int'(calc(4, 8'h07, 8'h01, 1'b0, 1'b0)), int'({1'b1, 1'b0, 8'h08}));

    repeat (2) @(negedge clk);
    chk("rst_S", int'(s0), 0);
    chk("rst_pronto", int'(p0), 1);
    chk("rst_done", int'(d0), 0);
    rst = 1'b0;

    op0(8'h5A, 8'h3C, 1'b0, 1'b0);
    wait_idle(0);
    chk("add_S", int'(s0), 8'h96);
    chk("add_C", int'(c0), 0);
    chk("add_ov", int'(v0), 1);

    op0(8'hFF, 8'h01, 1'b1, 1'b0);
    lowc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (p0) break;
      lowc++;
    end
    chk("carry_pronto_low", lowc, 5);
    chk("carry_S", int'(s0), 8'h01);
    chk("carry_C", int'(c0), 1);
    chk("carry_ov", int'(v0), 0);

    op0(8'h10, 8'h20, 1'b0, 1'b1);
    wait_idle(0);
    chk("sub_S", int'(s0), 8'hF0);
    chk("sub_C", int'(c0), 0);
    chk("sub_ov", int'(v0), 0);
    op0(8'h80, 8'h01, 1'b0, 1'b1);
    wait_idle(0);
    chk("subov_S", int'(s0), 8'h7F);
    chk("subov_C", int'(c0), 1);
    chk("subov_ov", int'(v0), 1);

    // start while busy must be ignored
    op0(8'h01, 8'h02, 1'b0, 1'b0);
    a_v[0] = 8'hAA; b_v[0] = 8'h55; start_v[0] = 1'b1;
    @(posedge clk); #2;
    start_v[0] = 1'b0;
    chk("busy_hold_S", int'(s0), 8'h7F);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (d0) ndone++;
    end
    chk("busy_ndone", ndone, 1);
    chk("busy_S", int'(s0), 8'h03);

    // reset in the second CALC cycle aborts the op
    op0(8'h33, 8'h44, 1'b0, 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("abort_S", int'(s0), 0);
    chk("abort_C", int'(c0), 0);
    chk("abort_ov", int'(v0), 0);
    chk("abort_pronto", int'(p0), 1);
    chk("abort_done", int'(d0), 0);
    @(negedge clk);
    rst = 1'b0;
    op0(8'h33, 8'h44, 1'b0, 1'b0);
    wait_idle(0);
    chk("after_abort_S", int'(s0), 8'h77);

    // random traffic with starts landing in every state
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      start_v[0] = ($urandom_range(0, 2) == 0);
      a_v[0] = 8'($urandom);
      b_v[0] = 8'($urandom);
      ci_v[0] = 1'($urandom);
      sub_v[0] = 1'($urandom);
    end
    start_v[0] = 1'b0;
    wait_idle(0);

    // exhaustive N=4 sweep on the serial and single-cycle variants
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int m = 0; m < 4; m++) begin
          wait_idle(1);
          wait_idle(2);
          for (int k = 1; k < 3; k++) begin
            a_v[k] = 8'(a); b_v[k] = 8'(b);
            ci_v[k] = m[0]; sub_v[k] = m[1];
          end
          start_v[1] = 1'b1; start_v[2] = 1'b1;
          @(posedge clk); #2;
          start_v[1] = 1'b0; start_v[2] = 1'b0;
        end
    wait_idle(1);
    wait_idle(2);
    @(posedge clk); #2;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/somador_serial_param.md
Name: somador_serial_param

Overview:
- Parametrised multi-cycle adder/subtractor, successor to the single-bit full adder.
- Adds or subtracts two N-bit operands D bits per clock, using a registered carry between digits.
- Start/ready/done handshake, so a datapath or sequencer can trade area for latency.
- Results are held stable until the next accepted operation.

Parameters:
- N, 8, operand/result width in bits; must be a multiple of D, N >= 2.
- D, 2, digit width processed per clock; 1 <= D <= N. Latency is N/D cycles.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when pronto=1.
- sub  in  1  mode: 0 = A+B+C_in, 1 = A-B-C_in. Sampled with operands.
- A  in  N  operand A, sampled on the accepting edge.
- B  in  N  operand B, sampled on the accepting edge.
- C_in  in  1  carry-in (add) or borrow-in (sub). Sampled on the accepting edge.
- pronto  out  1  ready; high only in IDLE.
- done  out  1  one-cycle pulse: S/C_out/overflow just updated.
- S  out  N  result.
- C_out  out  1  raw carry-out of the MSB digit. In sub mode, 1 = no borrow.
- overflow  out  1  two's-complement signed overflow of the result.

Behaviour:
- Reset (async, any state):
  - FSM goes to IDLE; digit counter = 0; internal shift registers cleared.
  - Outputs: S=0, C_out=0, overflow=0, done=0, pronto=1.
  - An operation in flight is aborted; no done is produced for it.
- FSM states: IDLE, CALC, FIM.
- IDLE:
  - pronto=1.
  - start=1 at an edge latches A, B' = sub ? ~B : B, and carry0 = sub ? ~C_in : C_in.
  - Counter is cleared and FSM goes to CALC.
  - start=0 keeps the FSM in IDLE.
- CALC:
  - pronto=0.
  - Each edge adds the low D bits of A and B' plus the carry register.
  - The D-bit sum is shifted in at the MSB end of the result shift register; A and B' shift right by D.
  - The carry register takes the digit carry-out; counter increments.
  - On the edge processing digit N/D-1:
    - S <= full result; C_out <= final carry.
    - overflow <= (A[N-1] == B'[N-1]) && (S[N-1] != A[N-1]), using the original latched MSBs.
    - FSM goes to FIM.
- FIM: done=1 for exactly this one cycle, pronto=0; next edge returns to IDLE.
- Latency: start accepted at edge t. Results and done become visible after edge t+N/D. pronto returns high after edge t+N/D+1.
- start while pronto=0 (CALC or FIM) is ignored. No queueing. Changes on A/B/sub/C_in after acceptance have no effect.
- S, C_out and overflow are not modified during CALC or FIM. They hold the previous result until the next completion.
- D=N is a legal degenerate case: one CALC cycle.
- Counter width is clog2(N/D), minimum 1. No wrap beyond N/D-1.

Test Plan (N=8, D=2 unless noted):
- Add: A=0x5A, B=0x3C, C_in=0, sub=0, start pulse -> after 4 edges done=1 for one cycle; S=0x96, C_out=0, overflow=1.
- Add with carry: A=0xFF, B=0x01, C_in=1 -> S=0x01, C_out=1, overflow=0. pronto low for 5 cycles, then high.
- Subtract with borrow: A=0x10, B=0x20, C_in=0, sub=1 -> S=0xF0, C_out=0, overflow=0. Then A=0x80, B=0x01, sub=1 -> S=0x7F, C_out=1, overflow=1.
- Busy start: accept A=0x01, B=0x02. One cycle later, start=1 with A=0xAA, B=0x55 -> ignored; single done with S=0x03. S keeps its prior value until that done.
- Reset mid-operation: assert rst during the 2nd CALC cycle -> immediately S=0, C_out=0, overflow=0, pronto=1; no done. A new start after release computes correctly.
- Sweep N=4, D=1 and N=4, D=4 over all A, B, C_in, sub combinations against a behavioural model -> all S/C_out/overflow match; latency 4 and 1 respectively.
